// File: rtl/btb_assoc.sv
// Set-associative branch target buffer with true-LRU replacement and 2-bit counters.
// A post-reset sweep invalidates one set per cycle before lookups and updates are honoured.
module btb_assoc #(
    parameter int SETS = 8,
    parameter int WAYS = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] PC,
    output logic        valid,
    output logic [31:0] target,
    output logic        predictedTaken,
    input  logic        update,
    input  logic [31:0] updatePC,
    input  logic [31:0] updateTarget,
    input  logic        taken,
    input  logic        mispredicted,
    output logic        ready
);
    localparam int IDX = $clog2(SETS);
    localparam int AW  = $clog2(WAYS);
    localparam int TAG = 30 - IDX;

    typedef enum logic {INIT, RUN} state_t;
    typedef logic [WAYS-1:0][AW-1:0] ages_t;

    state_t             state, state_nxt;
    logic [IDX-1:0]     ptr, ptr_nxt;

    logic [WAYS-1:0][TAG-1:0] tag_arr [SETS];
    logic [WAYS-1:0][31:0]    tgt_arr [SETS];
    logic [WAYS-1:0][1:0]     cnt_arr [SETS];
    logic [WAYS-1:0]          vld_arr [SETS];
    ages_t                    age_arr [SETS];

    logic [IDX-1:0] l_idx, u_idx;
    logic [TAG-1:0] l_tag, u_tag;
    logic           l_hit, u_hit, found_inv;
    logic [AW-1:0]  l_way, u_way_hit, victim, u_way;
    logic [1:0]     u_cnt, cnt_new;
    logic           rewrite, do_write, l_touch;
    ages_t          u_ages, l_ages;
    logic           unused_pc_bits;

    assign l_idx = PC[IDX+1:2];
    assign l_tag = PC[31:IDX+2];
    assign u_idx = updatePC[IDX+1:2];
    assign u_tag = updatePC[31:IDX+2];
    assign unused_pc_bits = ^{PC[1:0], updatePC[1:0]};

    // Touched way becomes age 0; younger ways age by one, keeping a permutation.
    function automatic ages_t touch(input ages_t ages, input logic [AW-1:0] way);
        ages_t res;
        res = ages;
        for (int w = 0; w < WAYS; w++) begin
            if (AW'(w) == way)
                res[w] = '0;
            else if (ages[w] < ages[way])
                res[w] = ages[w] + AW'(1);
        end
        return res;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= INIT;
            ptr   <= '0;
        end else begin
            state <= state_nxt;
            ptr   <= ptr_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        ptr_nxt   = ptr;
        if (state == INIT) begin
            ptr_nxt = ptr + IDX'(1);
            if (ptr == IDX'(SETS - 1))
                state_nxt = RUN;
        end
    end

    assign ready = (state == RUN);

    // Tag match for both ports, plus victim choice for a possible allocation.
    always_comb begin
        l_hit     = 1'b0;
        l_way     = '0;
        u_hit     = 1'b0;
        u_way_hit = '0;
        victim    = '0;
        found_inv = 1'b0;
        for (int w = 0; w < WAYS; w++) begin
            if (vld_arr[l_idx][w] && tag_arr[l_idx][w] == l_tag) begin
                l_hit = 1'b1;
                l_way = AW'(w);
            end
            if (vld_arr[u_idx][w] && tag_arr[u_idx][w] == u_tag) begin
                u_hit     = 1'b1;
                u_way_hit = AW'(w);
            end
        end
        for (int w = 0; w < WAYS; w++) begin
            if (!found_inv && !vld_arr[u_idx][w]) begin
                found_inv = 1'b1;
                victim    = AW'(w);
            end
        end
        if (!found_inv) begin
            for (int w = 0; w < WAYS; w++) begin
                if (age_arr[u_idx][w] == AW'(WAYS - 1))
                    victim = AW'(w);
            end
        end
    end

    assign u_way    = u_hit ? u_way_hit : victim;
    assign u_cnt    = cnt_arr[u_idx][u_way];
    assign cnt_new  = taken ? ((u_cnt == 2'd3) ? 2'd3 : u_cnt + 2'd1)
                            : ((u_cnt == 2'd0) ? 2'd0 : u_cnt - 2'd1);
    assign rewrite  = taken & (mispredicted | ~u_cnt[1]);
    assign do_write = (state == RUN) & update & (u_hit | taken);
    // An update to the same set owns that set's LRU this cycle.
    assign l_touch  = (state == RUN) & l_hit & ~(update & (u_idx == l_idx));
    assign u_ages   = touch(age_arr[u_idx], u_way);
    assign l_ages   = touch(age_arr[l_idx], l_way);

    always_ff @(posedge clk) begin
        if (rst || state != RUN) begin
            valid          <= 1'b0;
            target         <= '0;
            predictedTaken <= 1'b0;
        end else begin
            valid          <= l_hit;
            target         <= l_hit ? tgt_arr[l_idx][l_way] : 32'd0;
            predictedTaken <= l_hit & cnt_arr[l_idx][l_way][1];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state == INIT) begin
                vld_arr[ptr] <= '0;
                for (int w = 0; w < WAYS; w++)
                    age_arr[ptr][w] <= AW'(w);
            end else begin
                if (do_write) begin
                    if (!u_hit) begin
                        tag_arr[u_idx][u_way] <= u_tag;
                        tgt_arr[u_idx][u_way] <= updateTarget;
                        cnt_arr[u_idx][u_way] <= 2'd2;
                        vld_arr[u_idx][u_way] <= 1'b1;
                    end else begin
                        cnt_arr[u_idx][u_way] <= cnt_new;
                        if (rewrite)
                            tgt_arr[u_idx][u_way] <= updateTarget;
                    end
                    age_arr[u_idx] <= u_ages;
                end
                if (l_touch)
                    age_arr[l_idx] <= l_ages;
            end
        end
    end
endmodule

// File: tb/tb_btb_assoc.sv
// Directed bench for btb_assoc: reset sweep, allocation, counters, LRU eviction,
// same-cycle read/write ordering and reset during operation.
module tb_btb_assoc;
    typedef struct {
        logic [31:0] pc;
        logic        upd;
        logic [31:0] upc;
        logic [31:0] utgt;
        logic        tk;
        logic        mp;
        logic        ev;
        logic [31:0] et;
        logic        ep;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] PC;
    logic        valid;
    logic [31:0] target;
    logic        predictedTaken;
    logic        update;
    logic [31:0] updatePC;
    logic [31:0] updateTarget;
    logic        taken;
    logic        mispredicted;
    logic        ready;

    int n_checks = 0;
    int n_fail   = 0;

    vec_t vecs [27];
    vec_t post [3];

    btb_assoc #(.SETS(8), .WAYS(2)) dut (
        .clk(clk),
        .rst(rst),
        .PC(PC),
        .valid(valid),
        .target(target),
        .predictedTaken(predictedTaken),
        .update(update),
        .updatePC(updatePC),
        .updateTarget(updateTarget),
        .taken(taken),
        .mispredicted(mispredicted),
        .ready(ready)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic vec_t mk(input logic [31:0] pc, input logic upd, input logic [31:0] upc,
                                input logic [31:0] utgt, input logic tk, input logic mp,
                                input logic ev, input logic [31:0] et, input logic ep);
        vec_t v;
        v.pc = pc; v.upd = upd; v.upc = upc; v.utgt = utgt; v.tk = tk; v.mp = mp;
        v.ev = ev; v.et = et; v.ep = ep;
        return v;
    endfunction

    task automatic check_output(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        end
    endtask

    // Drive one cycle of inputs after a falling edge, then check the registered lookup.
    task automatic apply_stimulus(input vec_t v, input string name);
        PC           = v.pc;
        update       = v.upd;
        updatePC     = v.upc;
        updateTarget = v.utgt;
        taken        = v.tk;
        mispredicted = v.mp;
        @(posedge clk);
        @(negedge clk);
        check_output({name, ".valid"}, {31'd0, valid}, {31'd0, v.ev});
        check_output({name, ".target"}, target, v.et);
        check_output({name, ".pt"}, {31'd0, predictedTaken}, {31'd0, v.ep});
    endtask

    task automatic sweep_wait(input string name);
        for (int i = 0; i < 8; i++) begin
            check_output({name, ".ready_low"}, {31'd0, ready}, 32'd0);
            @(posedge clk);
            @(negedge clk);
            check_output({name, ".valid_init"}, {31'd0, valid}, 32'd0);
        end
        check_output({name, ".ready_high"}, {31'd0, ready}, 32'd1);
    endtask

    initial begin
        // idx = PC[4:2]; 0x100, 0x200, 0x300 share set 0, 0x104 is in set 1.
        vecs[0]  = mk(32'h100, 0, 0,      0,      0, 0, 0, 32'h0,   0);
        vecs[1]  = mk(32'h000, 1, 32'h100, 32'h400, 1, 0, 0, 32'h0,   0);
        vecs[2]  = mk(32'h100, 0, 0,      0,      0, 0, 1, 32'h400, 1);
        vecs[3]  = mk(32'h100, 1, 32'h100, 32'h0,   0, 0, 1, 32'h400, 1);
        vecs[4]  = mk(32'h100, 1, 32'h100, 32'h0,   0, 0, 1, 32'h400, 0);
        vecs[5]  = mk(32'h100, 1, 32'h100, 32'h0,   0, 0, 1, 32'h400, 0);
        vecs[6]  = mk(32'h100, 1, 32'h100, 32'h400, 1, 0, 1, 32'h400, 0);
        vecs[7]  = mk(32'h100, 1, 32'h100, 32'h400, 1, 0, 1, 32'h400, 0);
        vecs[8]  = mk(32'h100, 0, 0,      0,      0, 0, 1, 32'h400, 1);
        vecs[9]  = mk(32'h100, 1, 32'h100, 32'h444, 1, 0, 1, 32'h400, 1);
        vecs[10] = mk(32'h100, 0, 0,      0,      0, 0, 1, 32'h400, 1);
        vecs[11] = mk(32'h100, 1, 32'h100, 32'h400, 1, 0, 1, 32'h400, 1);
        vecs[12] = mk(32'h100, 1, 32'h100, 32'h0,   0, 0, 1, 32'h400, 1);
        vecs[13] = mk(32'h100, 0, 0,      0,      0, 0, 1, 32'h400, 1);
        vecs[14] = mk(32'h000, 1, 32'h200, 32'h600, 1, 0, 0, 32'h0,   0);
        vecs[15] = mk(32'h200, 0, 0,      0,      0, 0, 1, 32'h600, 1);
        vecs[16] = mk(32'h100, 0, 0,      0,      0, 0, 1, 32'h400, 1);
        vecs[17] = mk(32'h000, 1, 32'h300, 32'h700, 0, 0, 0, 32'h0,   0);
        vecs[18] = mk(32'h300, 0, 0,      0,      0, 0, 0, 32'h0,   0);
        vecs[19] = mk(32'h200, 1, 32'h300, 32'h700, 1, 0, 1, 32'h600, 1);
        vecs[20] = mk(32'h300, 0, 0,      0,      0, 0, 1, 32'h700, 1);
        vecs[21] = mk(32'h100, 0, 0,      0,      0, 0, 1, 32'h400, 1);
        vecs[22] = mk(32'h200, 0, 0,      0,      0, 0, 0, 32'h0,   0);
        vecs[23] = mk(32'h100, 1, 32'h100, 32'h500, 1, 1, 1, 32'h400, 1);
        vecs[24] = mk(32'h100, 0, 0,      0,      0, 0, 1, 32'h500, 1);
        vecs[25] = mk(32'h104, 1, 32'h104, 32'h800, 1, 0, 0, 32'h0,   0);
        vecs[26] = mk(32'h104, 0, 0,      0,      0, 0, 1, 32'h800, 1);

        post[0]  = mk(32'h100, 0, 0, 0, 0, 0, 0, 32'h0, 0);
        post[1]  = mk(32'h300, 0, 0, 0, 0, 0, 0, 32'h0, 0);
        post[2]  = mk(32'h104, 0, 0, 0, 0, 0, 0, 32'h0, 0);

        rst = 1'b1; PC = '0; update = 1'b0; updatePC = '0; updateTarget = '0;
        taken = 1'b0; mispredicted = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_output("reset.ready", {31'd0, ready}, 32'd0);
        check_output("reset.valid", {31'd0, valid}, 32'd0);
        check_output("reset.target", target, 32'd0);
        check_output("reset.pt", {31'd0, predictedTaken}, 32'd0);

        // Updates offered throughout the sweep must be discarded.
        rst = 1'b0; PC = 32'h100;
        update = 1'b1; updatePC = 32'h100; updateTarget = 32'h999; taken = 1'b1; mispredicted = 1'b1;
        sweep_wait("sweep");
        update = 1'b0;

        for (int i = 0; i < 27; i++)
            apply_stimulus(vecs[i], $sformatf("vec%0d", i));

        // Reset with a hitting lookup in flight.
        rst = 1'b1; PC = 32'h100; update = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check_output("midrst.valid", {31'd0, valid}, 32'd0);
        check_output("midrst.target", target, 32'd0);
        check_output("midrst.pt", {31'd0, predictedTaken}, 32'd0);
        check_output("midrst.ready", {31'd0, ready}, 32'd0);
        rst = 1'b0;
        sweep_wait("resweep");

        for (int i = 0; i < 3; i++)
            apply_stimulus(post[i], $sformatf("post%0d", i));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
